// File: rtl/bus_addr_router.sv
// Registered bus address router: decodes a device index from a high address field,
// drives a one-hot device enable with the in-region offset and returns done/error.
module bus_addr_router #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_DEV    = 8,
    parameter int SEL_LSB    = 23,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] phys_addr,
    output logic                  dev_we,
    output logic [NUM_DEV-1:0]    device_en,
    input  logic [NUM_DEV-1:0]    dev_ack,
    output logic                  resp_done,
    output logic                  resp_err,
    output logic                  busy
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // ACTIVE | device_en driven, waiting for the selected device's ack or timeout
    // RESP   | one-cycle resp_done/resp_err pulse

    localparam int DEV_BITS = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CNT_BITS = $clog2(TIMEOUT);
    localparam int HI_LSB   = SEL_LSB + DEV_BITS;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ~({ADDR_WIDTH{1'b1}} << SEL_LSB);
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [DEV_BITS-1:0]     req_idx;
    logic [DEV_BITS-1:0]     sel_idx, sel_idx_nxt;
    logic [CNT_BITS-1:0]     cnt, cnt_nxt;
    logic                    hi_zero;
    logic                    mapped;
    logic [NUM_DEV-1:0]      device_en_nxt;
    logic [ADDR_WIDTH-1:0]   phys_nxt;
    logic                    dev_we_nxt;
    logic                    done_nxt;
    logic                    err_nxt;

    assign req_idx   = req_addr[HI_LSB-1:SEL_LSB];
    assign hi_zero   = ((req_addr >> HI_LSB) == '0);
    assign mapped    = hi_zero && ({1'b0, req_idx} < (DEV_BITS+1)'(NUM_DEV));
    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        sel_idx_nxt   = sel_idx;
        cnt_nxt       = cnt;
        device_en_nxt = device_en;
        phys_nxt      = phys_addr;
        dev_we_nxt    = dev_we;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (mapped) begin
                        state_nxt     = ACTIVE;
                        sel_idx_nxt   = req_idx;
                        device_en_nxt = NUM_DEV'(1) << req_idx;
                        phys_nxt      = req_addr & OFF_MASK;
                        dev_we_nxt    = req_we;
                        cnt_nxt       = '0;
                    end else begin
                        state_nxt     = RESP;
                        device_en_nxt = '0;
                        phys_nxt      = '0;
                        dev_we_nxt    = 1'b0;
                        done_nxt      = 1'b1;
                        err_nxt       = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // ack is checked first so it wins over a simultaneous timeout
                if (dev_ack[sel_idx]) begin
                    state_nxt     = RESP;
                    device_en_nxt = '0;
                    dev_we_nxt    = 1'b0;
                    done_nxt      = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt     = RESP;
                    device_en_nxt = '0;
                    dev_we_nxt    = 1'b0;
                    done_nxt      = 1'b1;
                    err_nxt       = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel_idx   <= '0;
            cnt       <= '0;
            device_en <= '0;
            phys_addr <= '0;
            dev_we    <= 1'b0;
            resp_done <= 1'b0;
            resp_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_idx   <= sel_idx_nxt;
            cnt       <= cnt_nxt;
            device_en <= device_en_nxt;
            phys_addr <= phys_nxt;
            dev_we    <= dev_we_nxt;
            resp_done <= done_nxt;
            resp_err  <= err_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule
